alu_ex_stage: RTL and testbench

- Execute-stage ALU. Consumes the 4-bit ALUOperation code from the ALU control decoder, plus operands from the register file/immediate mux.
- Produces a registered result and a Zero flag for branch resolution (BEQ).
- AND/OR/NOR/ADD/SUB/LUI/LW/SW complete in one cycle. SLL/SRL run on an iterative 1-bit-per-cycle shifter, so the block has a start/busy/done handshake toward the control FSM.

---
 rtl/alu_ex_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_ex_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
// -----------------------------------------------------------------------------
// alu_ex_stage
//   Execute-stage ALU. Single-cycle logic/arithmetic operations plus an
//   iterative 1-bit-per-cycle shifter for SLL/SRL. A start/busy/done handshake
//   lets the control FSM issue work and learn when ALUResult/Zero were updated.
//
// Ports
//   i_clk          system clock, all state changes on the rising edge
//   i_reset        synchronous, active-high reset (wins over everything)
//   i_start        request, sampled only while o_busy = 0
//   i_alu_op       4-bit ALUOperation code from the ALU control decoder
//   i_a            operand A (rs)
//   i_b            operand B (rt or sign-extended immediate)
//   i_shamt        shift amount for SLL/SRL
//   o_busy         high while a multi-cycle shift is in progress
//   o_done         one-cycle pulse: o_alu_result / o_zero just updated
//   o_alu_result   registered result, held until the next completion
//   o_zero         registered, equals (o_alu_result == 0)
//
// WIDTH must be at least 17 so that LUI can place B[15:0] in the upper half.
// -----------------------------------------------------------------------------
module alu_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [3:0]         i_alu_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_alu_result,
  output logic               o_zero
);

  // Operation codes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;

  // FSM states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   RES_ZERO = {WIDTH{1'b0}};

  // State
  logic [0:0]         r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_dir_left;

  // Combinational helpers
  logic               w_accept;
  logic               w_op_is_shift;
  logic               w_op_left;
  logic               w_shamt_zero;
  logic               w_shamt_one;
  logic               w_accept_single;
  logic               w_accept_multi;
  logic               w_shift_last;
  logic               w_complete;
  logic [WIDTH-1:0]   w_logic_result;
  logic [WIDTH-1:0]   w_b_step1;
  logic [WIDTH-1:0]   w_work_step;
  logic [WIDTH-1:0]   w_first_result;
  logic [WIDTH-1:0]   w_complete_value;
  logic [0:0]         w_state_next;

  // A request is only accepted while idle; start during SHIFT is dropped.
  assign w_accept      = (r_state == ST_IDLE) && i_start;
  assign w_op_is_shift = (i_alu_op == OP_SRL) || (i_alu_op == OP_SLL);
  assign w_op_left     = (i_alu_op == OP_SLL);
  assign w_shamt_zero  = (i_shamt == CNT_ZERO);
  assign w_shamt_one   = (i_shamt == CNT_ONE);

  // First shift step is applied already at the accepting edge, so a shift by
  // s finishes after s edges in total and shamt=1 completes like a 1-cycle op.
  assign w_b_step1   = w_op_left ? {i_b[WIDTH-2:0], 1'b0} : {1'b0, i_b[WIDTH-1:1]};
  assign w_work_step = r_dir_left ? {r_work[WIDTH-2:0], 1'b0} : {1'b0, r_work[WIDTH-1:1]};

  assign w_accept_single = w_accept && (!w_op_is_shift || w_shamt_zero || w_shamt_one);
  assign w_accept_multi  = w_accept && w_op_is_shift && !w_shamt_zero && !w_shamt_one;

  // Completion of a multi-cycle shift: the counter is about to go 1 -> 0.
  assign w_shift_last = (r_state == ST_SHIFT) && (r_cnt == CNT_ONE);
  assign w_complete   = w_accept_single || w_shift_last;

  // Single-cycle operation results (shift codes pass B through here; the
  // shifted forms are selected below).
  always_comb begin
    w_logic_result = RES_ZERO;
    case (i_alu_op)
      OP_AND:  w_logic_result = i_a & i_b;
      OP_OR:   w_logic_result = i_a | i_b;
      OP_NOR:  w_logic_result = ~(i_a | i_b);
      OP_ADD:  w_logic_result = i_a + i_b;
      OP_SUB:  w_logic_result = i_a - i_b;
      OP_LUI:  w_logic_result = {i_b[15:0], {(WIDTH-16){1'b0}}};
      OP_SRL:  w_logic_result = i_b;
      OP_SLL:  w_logic_result = i_b;
      OP_LW:   w_logic_result = i_a + i_b;
      OP_SW:   w_logic_result = i_a + i_b;
      default: w_logic_result = i_a + i_b;  // unused codes behave as ADD
    endcase
  end

  // Value written at an accepting edge that completes immediately.
  always_comb begin
    w_first_result = w_logic_result;
    if (w_op_is_shift && !w_shamt_zero) begin
      w_first_result = w_b_step1;
    end else begin
      w_first_result = w_logic_result;
    end
  end

  // Selects which completion source updates the result register.
  always_comb begin
    w_complete_value = w_first_result;
    if (w_shift_last) begin
      w_complete_value = w_work_step;
    end else begin
      w_complete_value = w_first_result;
    end
  end

  // Next-state logic of the IDLE/SHIFT controller.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_multi) begin
          w_state_next = ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_shift_last) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_SHIFT;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Controller state and registered busy flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == ST_SHIFT);
    end
  end

  // Iterative shifter: working register, remaining-step counter, direction.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_work     <= RES_ZERO;
      r_cnt      <= CNT_ZERO;
      r_dir_left <= 1'b0;
    end else if (w_accept && w_op_is_shift && !w_shamt_zero) begin
      r_work     <= w_b_step1;
      r_cnt      <= i_shamt - CNT_ONE;
      r_dir_left <= w_op_left;
    end else if (r_state == ST_SHIFT) begin
      r_work     <= w_work_step;
      r_cnt      <= r_cnt - CNT_ONE;
      r_dir_left <= r_dir_left;
    end else begin
      r_work     <= r_work;
      r_cnt      <= r_cnt;
      r_dir_left <= r_dir_left;
    end
  end

  // Result, Zero flag and done pulse; only completion edges touch the result.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result <= RES_ZERO;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_complete) begin
        r_result <= w_complete_value;
        r_zero   <= (w_complete_value == RES_ZERO);
      end else begin
        r_result <= r_result;
        r_zero   <= r_zero;
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_alu_result = r_result;
  assign o_zero       = r_zero;

endmodule

// File: tb/tb_alu_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_ex_stage
//   Self-checking bench for alu_ex_stage: directed cases followed by random
//   operations compared against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic        zero;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_res = 32'd0;

  always #5 clk = ~clk;

  alu_ex_stage #(.WIDTH(32), .SHAMT_W(5)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_alu_op     (op),
    .i_a          (a),
    .i_b          (b),
    .i_shamt      (shamt),
    .o_busy       (busy),
    .o_done       (done),
    .o_alu_result (res),
    .o_zero       (zero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: what each operation code means, in plain arithmetic.
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input int s);
    case (o)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return ~(x | y);
      4'd3:    return x + y;
      4'd4:    return x - y;
      4'd5:    return y << 16;
      4'd6:    return y >> s;
      4'd7:    return y << s;
      default: return x + y;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] o, input int s);
    if ((o == 4'd6 || o == 4'd7) && s > 0) return s;
    return 1;
  endfunction

  // Issue one operation and follow it to completion.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s, input bit noise);
    logic [31:0] er;
    int el;
    int n;
    er = model(o, x, y, int'(s));
    el = latency(o, int'(s));
    op = o; a = x; b = y; shamt = s; start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      chk({tag, "/busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "/hold"}, res, prev_res);
      op = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
      start = noise ? 1'($urandom) : 1'b0;
      tick;
      start = 1'b0;
      n++;
    end
    chk({tag, "/lat"},  32'(n), 32'(el));
    chk({tag, "/done"}, {31'd0, done}, 32'd1);
    chk({tag, "/bsy0"}, {31'd0, busy}, 32'd0);
    chk({tag, "/res"},  res, er);
    chk({tag, "/zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
    prev_res = er;
    tick;
    chk({tag, "/done0"}, {31'd0, done}, 32'd0);
    chk({tag, "/keep"},  res, er);
  endtask

  initial begin
    bit saw_done;
    logic [3:0] ro;
    logic [4:0] rs;

    reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; shamt = 5'd0;
    tick;
    tick;
    chk("rst/busy", {31'd0, busy}, 32'd0);
    chk("rst/done", {31'd0, done}, 32'd0);
    chk("rst/res",  res, 32'd0);
    chk("rst/zero", {31'd0, zero}, 32'd1);
    reset = 1'b0;

    run_op("add_ovf", 4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
    run_op("sub_eq",  4'b0100, 32'h0000_1234, 32'h0000_1234, 5'd0, 1'b0);
    run_op("add_nz",  4'b0011, 32'h0000_0005, 32'h0000_0006, 5'd0, 1'b0);

    // Reset in the middle of a long shift: aborted, no completion later.
    op = 4'b0111; b = 32'd1; shamt = 5'd20; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    chk("midrst/busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick;
    tick;
    chk("midrst/busy", {31'd0, busy}, 32'd0);
    chk("midrst/done", {31'd0, done}, 32'd0);
    chk("midrst/res",  res, 32'd0);
    chk("midrst/zero", {31'd0, zero}, 32'd1);
    reset = 1'b0;
    prev_res = 32'd0;
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick;
    end
    chk("midrst/no_done", {31'd0, saw_done}, 32'd0);

    run_op("sll31",   4'b0111, 32'h0,         32'h0000_0001, 5'd31, 1'b1);
    run_op("srl4",    4'b0110, 32'h0,         32'h8000_0000, 5'd4,  1'b0);
    run_op("srl0",    4'b0110, 32'h0,         32'h8000_0000, 5'd0,  1'b0);
    run_op("sll1",    4'b0111, 32'h0,         32'h4000_0001, 5'd1,  1'b0);
    run_op("lui",     4'b0101, 32'h1234_5678, 32'h0000_ABCD, 5'd0,  1'b0);
    run_op("nor0",    4'b0010, 32'h0,         32'h0,         5'd0,  1'b0);
    run_op("op1111",  4'b1111, 32'd3,         32'd4,         5'd0,  1'b0);

    // Back-to-back single-cycle issue with start held high.
    op = 4'b0000; a = 32'hF0F0_1234; b = 32'h0FF0_FF00; shamt = 5'd0; start = 1'b1;
    tick;
    chk("b2b/and_done", {31'd0, done}, 32'd1);
    chk("b2b/and_res",  res, 32'h00F0_1200);
    op = 4'b0001;
    tick;
    chk("b2b/or_done", {31'd0, done}, 32'd1);
    chk("b2b/or_res",  res, 32'hFFF0_FF34);
    op = 4'b1001; a = 32'h1001_0000; b = 32'h0000_0008;
    tick;
    chk("b2b/sw_done", {31'd0, done}, 32'd1);
    chk("b2b/sw_res",  res, 32'h1001_0008);
    chk("b2b/sw_zero", {31'd0, zero}, 32'd0);
    start = 1'b0;
    tick;
    chk("b2b/idle", {31'd0, done}, 32'd0);
    prev_res = 32'h1001_0008;

    // Random operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      ro = 4'($urandom);
      rs = ($urandom_range(3, 0) == 0) ? 5'($urandom) : 5'($urandom_range(3, 0));
      run_op("rand", ro, $urandom, $urandom, rs, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
